uart_tx: RTL
============

# uart_tx

Serial UART transmitter: the transmit-side counterpart of the existing UART receive path, covering configuration, oversampling and state checking. It accepts parallel words over a valid/ready handshake and serialises each one onto a single idle-high line, LSB first. Each frame has a start bit, the data bits, an optional even parity bit, and one or two stop bits. The parity and stop-bit configuration bits come from the same configuration registers that drive the receiver, so both directions of a link share framing.

## Interface
- WIDTH_DATABITS, 8, data bits per frame
- BIT_CYCLES, 16, clk cycles per serial bit (≥ 2); baud counter width = $clog2(BIT_CYCLES)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset; synchronous, active-high (1 = reset)
- parity_bit_config  input  1  1 = append even parity bit; 0 = no parity
- stop_bit_config  input  1  0 = one stop bit; 1 = two stop bits
- in  input  WIDTH_DATABITS  word to transmit
- valid_in  input  1  `in` holds a valid word
- ready_in  output  1  1 = transmitter idle, will accept a word this cycle
- tx  output  1  serial line, idle high
- busy  output  1  1 while a frame is being shifted out
- done  output  1  one-cycle pulse when the last stop bit completes

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - ready_in=1, tx=1, busy=0.
  - On valid_in && ready_in, latch `in`, parity_bit_config and stop_bit_config into internal registers, then go to START.
- Config latching:
  - Config changes mid-frame do not affect the frame in progress.
  - The latched config applies to the whole frame.
- START: tx=0 for BIT_CYCLES cycles, then go to DATA.
- DATA:
  - tx = shift register LSB; shift right every BIT_CYCLES cycles.
  - Bit counter runs 0..WIDTH_DATABITS-1.
  - After the last bit, go to PARITY if parity is enabled, else go to STOP.
- PARITY:
  - tx = XOR of all latched data bits (even parity: total number of ones including the parity bit is even).
  - Lasts BIT_CYCLES cycles, then go to STOP.
- STOP:
  - tx=1 for BIT_CYCLES cycles (one stop bit) or 2×BIT_CYCLES cycles (two stop bits).
  - Then go to IDLE and pulse done.
- valid_in while ready_in=0 is ignored. There is no buffering; the source must hold the word until the handshake.
- Reset values: state=IDLE, tx=1, ready_in=1, busy=0, done=0; baud counter, bit counter and shift register = 0.
- Reset mid-frame: the frame is abandoned. tx returns to 1 on the reset edge and no done pulse is emitted.

## Timing
- Outputs are registered.
- If handshake occurs in cycle N, then in cycle N+1: tx falls to 0, busy=1, ready_in=0.
- Frame length = (1 + WIDTH_DATABITS + P + S) × BIT_CYCLES cycles, with P∈{0,1} and S∈{1,2}.
- Each bit holds for exactly BIT_CYCLES cycles; no jitter.
- done=1 and ready_in=1 in the first IDLE cycle after the last stop cycle; busy=0 in that same cycle.
- Back-to-back frames:
  - A word presented with valid_in high in that first IDLE cycle is accepted there.
  - Its start bit begins on the next cycle.
  - The minimum gap between frames is therefore one clk of idle-high beyond the stop bits.
- Simultaneous rst_n and valid_in: reset wins and the word is not accepted.

## Test plan
- BIT_CYCLES=4, parity off, 1 stop, send 0xA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frame is 40 cycles; done pulses once at cycle 41.
- Parity on, 1 stop, send 0x07 → after data bits 1,1,1,0,0,0,0,0 the parity bit is 1, then stop; frame is 44 cycles. Send 0x03 → parity bit 0.
- Parity off, 2 stops, send 0xFF → tx low for 4 cycles, then high for 40 cycles; done after cycle 44.
- Send 0x12, hold valid_in high with 0x34 during the frame → 0x34 is ignored until ready_in rises, is accepted in the done cycle, and its start bit follows immediately; two complete frames, 0x12 then 0x34.
- Toggle parity_bit_config mid-frame of 0x55 → the frame keeps the config latched at the handshake; the next frame uses the new value.
- Assert rst_n during DATA of 0xC3 → tx=1, ready_in=1, busy=0 on the next edge; no done pulse; a following send of 0x81 produces a correct full frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Word handshake between a data source and the UART transmitter.
interface uart_tx_if #(
  parameter int WIDTH_DATABITS = 8
);
  logic [WIDTH_DATABITS-1:0] in;
  logic                      valid_in;
  logic                      ready_in;

  modport master (output in, output valid_in, input ready_in);
  modport slave  (input in, input valid_in, output ready_in);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, 1 or 2 stop bits.
// All outputs are registered; framing config is captured at the handshake.
module uart_tx #(
  parameter int WIDTH_DATABITS = 8,
  parameter int BIT_CYCLES     = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     parity_bit_config,
  input  logic     stop_bit_config,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy,
  output logic     done
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int BW = (WIDTH_DATABITS > 1) ? $clog2(WIDTH_DATABITS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH_DATABITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]                state;
  logic [CW-1:0]             baud;
  logic [BW-1:0]             bit_cnt;
  logic [WIDTH_DATABITS-1:0] shreg;
  logic [WIDTH_DATABITS-1:0] sh_next;
  logic                      par_en, two_stop, par_bit, stop_cnt, ready_q;
  logic                      bit_end;

  assign bus.ready_in = ready_q;
  assign sh_next      = shreg >> 1;
  assign bit_end      = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      two_stop <= 1'b0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
      ready_q  <= 1'b1;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE)
        baud <= bit_end ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          if (bus.valid_in && ready_q) begin
            shreg    <= bus.in;
            par_en   <= parity_bit_config;
            two_stop <= stop_bit_config;
            par_bit  <= ^bus.in;
            baud     <= '0;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx      <= shreg[0];
          end
        end
        DATA: begin
          // tx is registered, so it is loaded with the bit the shift exposes
          if (bit_end) begin
            shreg <= sh_next;
            if (bit_cnt == BIT_LAST) begin
              stop_cnt <= 1'b0;
              state    <= par_en ? PARITY : STOP;
              tx       <= par_en ? par_bit : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= sh_next[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            stop_cnt <= 1'b0;
            state    <= STOP;
            tx       <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (two_stop && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state   <= IDLE;
              done    <= 1'b1;
              ready_q <= 1'b1;
              busy    <= 1'b0;
              tx      <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy    <= 1'b0;
          tx      <= 1'b1;
        end
      endcase
    end
  end
endmodule
